// File: rtl/barrett_sched_pkg.sv
// rtl/barrett_sched_pkg.sv - shared types for the barrett reducer scheduler
//
// Purpose: FSM state encoding and the tag that travels alongside each
// operand through the reducer pipeline.
// Ports: none (package).
package barrett_sched_pkg;

   typedef enum logic [1:0] {
      ST_UNCFG  = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_COMMIT = 2'd3
   } sched_state_e;

   // The id field is sized for the largest supported requester count (16);
   // smaller configurations zero-extend the winner index into it.
   localparam int unsigned TAG_ID_W = 4;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/barrett_sched_if.sv
// rtl/barrett_sched_if.sv - requester-side bus of the barrett reducer scheduler
//
// Purpose: bundles the per-requester operand handshake and the shared
// result bus. Signal suffixes are from the scheduler's point of view.
// Ports (signals):
//   req_valid_i  per-requester operand valid
//   req_x_i      per-requester operand x
//   req_ready_o  one-hot grant
//   rsp_valid_o  one-hot result strobe
//   rsp_data_o   shared result x mod m
// Modports: slave = scheduler side, master = requester side.
interface barrett_sched_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 64
);

   logic [NUM_REQ-1:0]            req_valid_i;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_x_i;
   logic [NUM_REQ-1:0]            req_ready_o;
   logic [NUM_REQ-1:0]            rsp_valid_o;
   logic [WIDTH-1:0]              rsp_data_o;

   modport slave (
      input  req_valid_i,
      input  req_x_i,
      output req_ready_o,
      output rsp_valid_o,
      output rsp_data_o
   );

   modport master (
      output req_valid_i,
      output req_x_i,
      input  req_ready_o,
      input  rsp_valid_o,
      input  rsp_data_o
   );

endinterface

// File: rtl/barrett_sched_rr_arbiter.sv
// rtl/barrett_sched_rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: picks the first asserted request at or after ptr_i, wrapping.
// Ports:
//   req_i  in  N          request vector
//   ptr_i  in  clog2(N)   highest-priority index
//   gnt_o  out N          one-hot grant (all zero when no request)
//   idx_o  out clog2(N)   winner index (0 when no request)
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] idx_o
);

   localparam int unsigned IW = $clog2(N);

   logic          found;
   logic [IW-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = IW'((32'(ptr_i) + i) % N);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/barrett_sched.sv
// rtl/barrett_sched.sv - round-robin scheduler in front of one barrett reducer
//
// Purpose: shares a single pipelined reducer among NUM_REQ requesters, tags
// each operand with its owner, routes results back and sequences modulus
// reconfiguration by draining the pipeline first.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   req_if (slave)                requester handshake + result bus
//   cfg_valid_i/cfg_m_i/cfg_mu_i  new modulus request (held until cfg_ready_o)
//   cfg_ready_o                   one-cycle pulse when m/mu are committed
//   red_start_o/red_x_o/red_m_o/red_mu_o  reducer operands
//   red_result_i/red_valid_i      reducer result
//   busy_o                        work in flight or not in RUN
//   err_o                         sticky tag/valid mismatch
module barrett_sched
   import barrett_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned PIPE_LAT = 6
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   barrett_sched_if.slave   req_if,
   input  logic             cfg_valid_i,
   input  logic [WIDTH-1:0] cfg_m_i,
   input  logic [WIDTH-1:0] cfg_mu_i,
   output logic             cfg_ready_o,
   output logic             red_start_o,
   output logic [WIDTH-1:0] red_x_o,
   output logic [WIDTH-1:0] red_m_o,
   output logic [WIDTH-1:0] red_mu_o,
   input  logic [WIDTH-1:0] red_result_i,
   input  logic             red_valid_i,
   output logic             busy_o,
   output logic             err_o
);

   localparam int unsigned IW = $clog2(NUM_REQ);
   // In-flight range is 0..PIPE_LAT+1 (start stage plus the tag pipeline).
   localparam int unsigned CW = $clog2(PIPE_LAT + 2);

   localparam logic [1:0] S_UNCFG  = ST_UNCFG;
   localparam logic [1:0] S_RUN    = ST_RUN;
   localparam logic [1:0] S_DRAIN  = ST_DRAIN;
   localparam logic [1:0] S_COMMIT = ST_COMMIT;

   logic [1:0]         state_q, state_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic [WIDTH-1:0]   mu_q, mu_d;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [IW-1:0]      arb_idx;
   logic               grant_en;
   logic               issue;

   logic               red_start_q;
   logic [WIDTH-1:0]   red_x_q, red_m_q, red_mu_q;
   tag_t               start_tag_q;
   tag_t               tag_sr_q [PIPE_LAT];
   tag_t               tag_out;
   logic               retire;
   logic               mismatch;

   logic [CW-1:0]      cnt_q, cnt_d;
   logic [CW-1:0]      mask_q;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0]   rsp_data_q;
   logic               cfg_ready_q;
   logic               busy_q;
   logic               err_q;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req_i (req_if.req_valid_i),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   // A pending cfg blocks grants even in RUN so the drain starts cleanly.
   assign grant_en           = (state_q == S_RUN) && !cfg_valid_i;
   assign req_if.req_ready_o = grant_en ? arb_gnt : '0;
   assign issue              = |req_if.req_ready_o;

   assign tag_out  = tag_sr_q[PIPE_LAT-1];
   assign retire   = tag_out.valid;
   assign mismatch = (red_valid_i != tag_out.valid);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      m_d     = m_q;
      mu_d    = mu_q;
      case (state_q)
         S_UNCFG: begin
            if (cfg_valid_i) state_d = S_COMMIT;
         end
         S_RUN: begin
            if (cfg_valid_i) begin
               state_d = S_DRAIN;
            end else if (issue) begin
               ptr_d = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
            end
         end
         S_DRAIN: begin
            // A late reducer beat still needs its tag, so wait for both.
            if ((cnt_q == '0) && !red_valid_i) state_d = S_COMMIT;
         end
         S_COMMIT: begin
            m_d     = cfg_m_i;
            mu_d    = cfg_mu_i;
            state_d = S_RUN;
         end
         default: state_d = S_UNCFG;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({issue, retire})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      rsp_valid_d = '0;
      if (tag_out.valid && red_valid_i) begin
         rsp_valid_d = NUM_REQ'(1) << tag_out.id;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_UNCFG;
         ptr_q       <= '0;
         m_q         <= '0;
         mu_q        <= '0;
         red_start_q <= 1'b0;
         red_x_q     <= '0;
         red_m_q     <= '0;
         red_mu_q    <= '0;
         start_tag_q <= '0;
         for (int i = 0; i < PIPE_LAT; i++) tag_sr_q[i] <= '0;
         cnt_q       <= '0;
         mask_q      <= CW'(PIPE_LAT + 1);
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         cfg_ready_q <= 1'b0;
         busy_q      <= 1'b1;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         m_q     <= m_d;
         mu_q    <= mu_d;

         red_start_q       <= issue;
         start_tag_q.valid <= issue;
         start_tag_q.id    <= TAG_ID_W'(arb_idx);
         if (issue) begin
            red_x_q  <= req_if.req_x_i[arb_idx];
            red_m_q  <= m_q;
            red_mu_q <= mu_q;
         end

         tag_sr_q[0] <= start_tag_q;
         for (int i = 1; i < PIPE_LAT; i++) tag_sr_q[i] <= tag_sr_q[i-1];

         cnt_q <= cnt_d;

         // Results from before a reset have no tags; ignore mismatches
         // until they have had time to flush out of the reducer.
         if (mask_q != '0) mask_q <= mask_q - CW'(1);
         if (mismatch && (mask_q == '0)) err_q <= 1'b1;

         rsp_valid_q <= rsp_valid_d;
         if (tag_out.valid && red_valid_i) rsp_data_q <= red_result_i;

         cfg_ready_q <= (state_d == S_COMMIT);
         busy_q      <= (cnt_d != '0) || (state_d != S_RUN);
      end
   end

   assign red_start_o        = red_start_q;
   assign red_x_o            = red_x_q;
   assign red_m_o            = red_m_q;
   assign red_mu_o           = red_mu_q;
   assign req_if.rsp_valid_o = rsp_valid_q;
   assign req_if.rsp_data_o  = rsp_data_q;
   assign cfg_ready_o        = cfg_ready_q;
   assign busy_o             = busy_q;
   assign err_o              = err_q;

endmodule

// File: tb/tb_barrett_sched.sv
// tb/tb_barrett_sched.sv - scoreboard bench for barrett_sched
module tb_barrett_sched;

   localparam int unsigned PIPE_LAT = 6;

   localparam logic [63:0] M1  = 64'h3A32E4C4C7A8C21B;
   localparam logic [63:0] MU1 = 64'h466123E72A6BDD53;
   localparam logic [63:0] M2  = 64'h00000000FFFFFFFB;
   localparam logic [63:0] MU2 = 64'h0000000100000005;

   typedef struct {
      logic [3:0]  onehot;
      logic [63:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid;
   logic [63:0] cfg_m, cfg_mu;
   logic        cfg_ready;
   logic        red_start;
   logic [63:0] red_x, red_m, red_mu;
   logic [63:0] red_result;
   logic        red_valid;
   logic        busy, err;

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   logic [63:0] m_cur = '0;
   logic [63:0] xv [4] = '{64'h0123456789ABCDEF, 64'hDEADBEEFCAFEF00D,
                           64'hFFFFFFFFFFFFFFFF, 64'h3A32E4C4C7A8C21B};
   exp_t        sb [$];
   exp_t        mon_e;
   int          lat;

   barrett_sched_if #(.NUM_REQ(4), .WIDTH(64)) ifc ();

   barrett_sched #(.NUM_REQ(4), .WIDTH(64), .PIPE_LAT(PIPE_LAT)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_if       (ifc),
      .cfg_valid_i  (cfg_valid),
      .cfg_m_i      (cfg_m),
      .cfg_mu_i     (cfg_mu),
      .cfg_ready_o  (cfg_ready),
      .red_start_o  (red_start),
      .red_x_o      (red_x),
      .red_m_o      (red_m),
      .red_mu_o     (red_mu),
      .red_result_i (red_result),
      .red_valid_i  (red_valid),
      .busy_o       (busy),
      .err_o        (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reducer model: fixed latency, not reset, so in-flight work survives a
   // scheduler reset the way a real pipeline would.
   bit          pv [PIPE_LAT];
   logic [63:0] pd [PIPE_LAT];
   bit          force_valid = 1'b0;

   always @(posedge clk) begin
      pv[0] <= red_start;
      pd[0] <= (red_m == 64'd0) ? red_x : (red_x % red_m);
      for (int i = 1; i < PIPE_LAT; i++) begin
         pv[i] <= pv[i-1];
         pd[i] <= pd[i-1];
      end
   end
   assign red_valid  = pv[PIPE_LAT-1] | force_valid;
   assign red_result = pd[PIPE_LAT-1];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && ifc.rsp_valid_o != 4'b0000) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_unexpected: got strobe %b data %h, expected none (cycle %0d)",
                     ifc.rsp_valid_o, ifc.rsp_data_o, cyc);
         end else begin
            mon_e = sb.pop_front();
            check("rsp_strobe", 64'(ifc.rsp_valid_o), 64'(mon_e.onehot));
            check("rsp_data", ifc.rsp_data_o, mon_e.data);
            check("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
         end
      end
   end

   // Tasks start at posedge+1 and return at the next posedge+1.
   task automatic tick(input logic [3:0] vld, input logic [3:0] exp_rdy,
                       input bit use_ovr, input logic [63:0] ovr);
      exp_t e;
      ifc.req_valid_i = vld;
      @(negedge clk);
      check("grant", 64'(ifc.req_ready_o), 64'(exp_rdy));
      for (int i = 0; i < 4; i++) begin
         if (exp_rdy[i] && vld[i]) begin
            e.onehot = 4'b0001 << i;
            e.data   = use_ovr ? ovr : (xv[i] % m_cur);
            e.cyc    = cyc + PIPE_LAT + 2;
            sb.push_back(e);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic do_cfg(input logic [63:0] m, input logic [63:0] mu,
                         input logic [3:0] vld, output int l);
      bit seen;
      seen = 1'b0;
      l = 0;
      cfg_valid = 1'b1;
      cfg_m = m;
      cfg_mu = mu;
      ifc.req_valid_i = vld;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         check("cfg_no_grant", 64'(ifc.req_ready_o), 64'd0);
         if (cfg_ready === 1'b1) seen = 1'b1;
         else begin
            @(posedge clk); #1;
            l++;
         end
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL cfg_timeout: got no cfg_ready_o, expected pulse within 20 cycles");
      end else begin
         m_cur = m;
      end
      @(posedge clk); #1;
      cfg_valid = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 64'(sb.size()), 64'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, 64'(ifc.req_ready_o), 64'd0);
      check({tag, "_rsp"}, 64'(ifc.rsp_valid_o), 64'd0);
      check({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd0);
      check({tag, "_start"}, 64'(red_start), 64'd0);
      check({tag, "_red_m"}, red_m, 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_err"}, 64'(err), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      cfg_valid = 1'b0;
      cfg_m = '0;
      cfg_mu = '0;
      ifc.req_valid_i = 4'b1111;
      for (int i = 0; i < 4; i++) ifc.req_x_i[i] = xv[i];
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Requests before any configuration are never granted.
      repeat (3) tick(4'b1111, 4'b0000, 1'b0, '0);
      do_cfg(M1, MU1, 4'b1111, lat);
      check("cfg_lat_uncfg", 64'(lat), 64'd1);
      tick(4'b1111, 4'b0001, 1'b0, '0);

      // Single op from requester 2 with a hand-reduced expected value.
      tick(4'b0100, 4'b0100, 1'b1, 64'h17346CECE15CF793);
      tick(4'b1000, 4'b1000, 1'b0, '0);

      // Fairness: pointer now at 0, every requester asserting.
      for (int i = 0; i < 8; i++) tick(4'b1111, 4'b0001 << (i % 4), 1'b0, '0);
      tick(4'b0000, 4'b0000, 1'b0, '0);
      wait_empty("fair_drain");
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_err", 64'(err), 64'd0);
      @(posedge clk); #1;

      // Reconfiguration with 5 operations in flight and requests pending.
      tick(4'b1111, 4'b0001, 1'b0, '0);
      tick(4'b1111, 4'b0010, 1'b0, '0);
      tick(4'b1111, 4'b0100, 1'b0, '0);
      tick(4'b1111, 4'b1000, 1'b0, '0);
      tick(4'b1111, 4'b0001, 1'b0, '0);
      do_cfg(M2, MU2, 4'b1111, lat);
      check("cfg_lat_drain_le", 64'(lat <= PIPE_LAT + 3), 64'd1);
      check("old_m_drained", 64'(sb.size()), 64'd0);
      // Pointer must not have moved during the blocked cycle.
      tick(4'b1111, 4'b0010, 1'b0, '0);
      tick(4'b0000, 4'b0000, 1'b0, '0);
      wait_empty("new_m_drain");

      // Reset with 4 operations in flight.
      tick(4'b1111, 4'b0100, 1'b0, '0);
      tick(4'b1111, 4'b1000, 1'b0, '0);
      tick(4'b1111, 4'b0001, 1'b0, '0);
      tick(4'b1111, 4'b0010, 1'b0, '0);
      rst_n = 1'b0;
      ifc.req_valid_i = 4'b0000;
      sb.delete();
      @(negedge clk);
      check_reset_vals("rst_mid");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (14) begin
         @(negedge clk);
         check("err_masked", 64'(err), 64'd0);
         @(posedge clk); #1;
      end

      // A reducer beat with no tag behind it is a mismatch.
      force_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      force_valid = 1'b0;
      @(negedge clk);
      check("err_set", 64'(err), 64'd1);
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
